// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: issues one data-bus access per load or store,
// stalls the front of the pipeline while the access is in flight, and
// registers the write-back fields toward the WB stage. Big-endian lanes.
module mem_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_sdata,
  output logic        d_req,
  output logic        d_we,
  output logic [31:0] d_addr,
  output logic [3:0]  d_sel,
  output logic [31:0] d_wdata,
  input  logic [31:0] d_rdata,
  input  logic        d_ack,
  output logic        stallreq,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata,
  output logic        addr_err
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic        is_load;
  logic        is_store;
  logic        acc_byte;
  logic        acc_half;
  logic        acc_word;
  logic        load_signed;
  logic        misaligned;
  logic        mem_access;
  logic [3:0]  req_sel;
  logic [31:0] req_wdata;

  logic        lat_load;
  logic        lat_signed;
  logic        lat_byte;
  logic        lat_half;
  logic [1:0]  lat_off;
  logic [31:0] load_data;

  logic [7:0]  ext_byte;
  logic [15:0] ext_half;
  logic [31:0] load_ext;

  // Decode the access type, alignment, lane mask and replicated store data.
  always_comb begin
    is_load     = 1'b0;
    is_store    = 1'b0;
    acc_byte    = 1'b0;
    acc_half    = 1'b0;
    acc_word    = 1'b0;
    load_signed = 1'b0;
    case (mem_op)
      OP_LB:  begin is_load  = 1'b1; acc_byte = 1'b1; load_signed = 1'b1; end
      OP_LBU: begin is_load  = 1'b1; acc_byte = 1'b1; end
      OP_LH:  begin is_load  = 1'b1; acc_half = 1'b1; load_signed = 1'b1; end
      OP_LHU: begin is_load  = 1'b1; acc_half = 1'b1; end
      OP_LW:  begin is_load  = 1'b1; acc_word = 1'b1; end
      OP_SB:  begin is_store = 1'b1; acc_byte = 1'b1; end
      OP_SH:  begin is_store = 1'b1; acc_half = 1'b1; end
      OP_SW:  begin is_store = 1'b1; acc_word = 1'b1; end
      default: ;
    endcase

    misaligned = (acc_half & mem_addr[0]) | (acc_word & (|mem_addr[1:0]));
    mem_access = (is_load | is_store) & ~misaligned;

    req_sel   = 4'b1111;
    req_wdata = mem_sdata;
    if (acc_byte) begin
      req_sel   = 4'b1000 >> mem_addr[1:0];
      req_wdata = {4{mem_sdata[7:0]}};
    end else if (acc_half) begin
      req_sel   = mem_addr[1] ? 4'b0011 : 4'b1100;
      req_wdata = {2{mem_sdata[15:0]}};
    end
  end

  // Pick the addressed lane out of the returned word and extend it.
  always_comb begin
    ext_byte = d_rdata[31:24];
    case (lat_off)
      2'd0: ext_byte = d_rdata[31:24];
      2'd1: ext_byte = d_rdata[23:16];
      2'd2: ext_byte = d_rdata[15:8];
      2'd3: ext_byte = d_rdata[7:0];
      default: ;
    endcase
    ext_half = lat_off[1] ? d_rdata[15:0] : d_rdata[31:16];

    load_ext = d_rdata;
    if (lat_byte) begin
      load_ext = {{24{lat_signed & ext_byte[7]}}, ext_byte};
    end else if (lat_half) begin
      load_ext = {{16{lat_signed & ext_half[15]}}, ext_half};
    end
  end

  // State register for the access sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state selection and the stall request held while an access is pending.
  always_comb begin
    next_state = state;
    stallreq   = 1'b0;
    case (state)
      IDLE: begin
        if (mem_access) begin
          stallreq   = 1'b1;
          next_state = BUS;
        end
      end
      BUS: begin
        stallreq = 1'b1;
        if (d_ack) begin
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Bus request registers, write-back registers and the misalignment pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_req      <= 1'b0;
      d_we       <= 1'b0;
      d_addr     <= 32'd0;
      d_sel      <= 4'd0;
      d_wdata    <= 32'd0;
      wb_wd      <= 5'd0;
      wb_wreg    <= 1'b0;
      wb_wdata   <= 32'd0;
      addr_err   <= 1'b0;
      lat_load   <= 1'b0;
      lat_signed <= 1'b0;
      lat_byte   <= 1'b0;
      lat_half   <= 1'b0;
      lat_off    <= 2'd0;
      load_data  <= 32'd0;
    end else begin
      addr_err <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_access) begin
            d_req      <= 1'b1;
            d_we       <= is_store;
            d_addr     <= {mem_addr[31:2], 2'b00};
            d_sel      <= req_sel;
            d_wdata    <= req_wdata;
            lat_load   <= is_load;
            lat_signed <= load_signed;
            lat_byte   <= acc_byte;
            lat_half   <= acc_half;
            lat_off    <= mem_addr[1:0];
            wb_wd      <= 5'd0;
            wb_wreg    <= 1'b0;
            wb_wdata   <= 32'd0;
          end else if (misaligned) begin
            addr_err <= 1'b1;
            wb_wd    <= 5'd0;
            wb_wreg  <= 1'b0;
            wb_wdata <= 32'd0;
          end else begin
            wb_wd    <= mem_wd;
            wb_wreg  <= mem_wreg;
            wb_wdata <= mem_wdata;
          end
        end
        BUS: begin
          wb_wd    <= 5'd0;
          wb_wreg  <= 1'b0;
          wb_wdata <= 32'd0;
          if (d_ack) begin
            d_req     <= 1'b0;
            load_data <= load_ext;
          end
        end
        DONE: begin
          if (lat_load) begin
            wb_wd    <= mem_wd;
            wb_wreg  <= 1'b1;
            wb_wdata <= load_data;
          end else begin
            wb_wd    <= 5'd0;
            wb_wreg  <= 1'b0;
            wb_wdata <= 32'd0;
          end
        end
        default: begin
          wb_wd    <= 5'd0;
          wb_wreg  <= 1'b0;
          wb_wdata <= 32'd0;
        end
      endcase
    end
  end

endmodule
